// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter that serialises two clients' read/write transactions onto
// a single register file write port and combinational read port.
module rf_access_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              op0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              op1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wAddr,
    output logic [DATA_W-1:0] rf_wData,
    output logic [ADDR_W-1:0] rf_rAddr,
    input  logic [DATA_W-1:0] rf_rData
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_id;
    logic              r_op;
    logic              r_last;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [ADDR_W-1:0] r_rf_raddr;

    logic              w_any_req;
    logic              w_grant_id;
    logic              w_sel_op;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // On a tie the client that was not served last wins; otherwise the lone requester.
    assign w_any_req   = req0 | req1;
    assign w_grant_id  = (req0 & req1) ? ~r_last : req1;
    assign w_sel_op    = w_grant_id ? op1    : op0;
    assign w_sel_addr  = w_grant_id ? addr1  : addr0;
    assign w_sel_wdata = w_grant_id ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_id       <= 1'b0;
            r_op       <= 1'b0;
            r_last     <= 1'b1;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_rf_raddr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_id       <= w_grant_id;
                        r_op       <= w_sel_op;
                        r_rf_raddr <= w_sel_addr;
                        r_rf_waddr <= w_sel_addr;
                        r_rf_wdata <= w_sel_wdata;
                        r_rf_we    <= w_sel_op;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // The register file commits the write on this same edge.
                    r_rf_we <= 1'b0;
                    if (!r_op) begin
                        if (r_id) r_rdata1 <= rf_rData;
                        else      r_rdata0 <= rf_rData;
                    end
                    if (r_id) r_ack1 <= 1'b1;
                    else      r_ack0 <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_last  <= r_id;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_rf_we <= 1'b0;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign rf_we    = r_rf_we;
    assign rf_wAddr = r_rf_waddr;
    assign rf_wData = r_rf_wdata;
    assign rf_rAddr = r_rf_raddr;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a behavioural 8 x 32 register file.
module tb_rf_access_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
    logic [2:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, rf_we;
    logic [31:0] rdata0, rdata1, rf_wData, rf_rData;
    logic [2:0]  rf_wAddr, rf_rAddr;

    logic [31:0] rf_mem [8];
    int n_vec = 0;
    int n_err = 0;

    rf_access_arbiter #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .op1(op1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .rf_we(rf_we), .rf_wAddr(rf_wAddr), .rf_wData(rf_wData),
        .rf_rAddr(rf_rAddr), .rf_rData(rf_rData)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 8; i++) rf_mem[i] = '0;
    always @(posedge clk) if (rf_we) rf_mem[rf_wAddr] <= rf_wData;
    assign rf_rData = rf_mem[rf_rAddr];

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one transaction from a single client; lat = cycles from grant edge to ack, -1 on timeout.
    task automatic xact(input int c, input logic op, input logic [2:0] a,
                        input logic [31:0] wd, output int lat);
        lat = -1;
        if (c == 0) begin req0 = 1'b1; op0 = op; addr0 = a; wdata0 = wd; end
        else        begin req1 = 1'b1; op1 = op; addr1 = a; wdata1 = wd; end
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((c == 0 ? ack0 : ack1) === 1'b1) lat = i;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (ack0 !== 1'b0)   begin n_err++; $display("FAIL reset_ack0 got %b want 0", ack0); end
        n_vec++; if (ack1 !== 1'b0)   begin n_err++; $display("FAIL reset_ack1 got %b want 0", ack1); end
        n_vec++; if (rf_we !== 1'b0)  begin n_err++; $display("FAIL reset_we got %b want 0", rf_we); end
        n_vec++; if (rf_wAddr !== 3'd0 || rf_rAddr !== 3'd0) begin n_err++; $display("FAIL reset_addr got w=%0d r=%0d want 0", rf_wAddr, rf_rAddr); end
        n_vec++; if (rf_wData !== 32'h0) begin n_err++; $display("FAIL reset_wdata got %h want 0", rf_wData); end
        n_vec++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h/%h want 0", rdata0, rdata1); end
        reset = 1'b0;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_single_write();
        req0 = 1'b1; op0 = 1'b1; addr0 = 3'd0; wdata0 = 32'h0000000f;
        @(posedge clk); @(negedge clk);
        n_vec++; if (rf_we !== 1'b1 || rf_wAddr !== 3'd0 || rf_wData !== 32'h0000000f) begin
            n_err++; $display("FAIL single_write_access got we=%b a=%0d d=%h want 1/0/0000000f", rf_we, rf_wAddr, rf_wData); end
        n_vec++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL single_write_early_ack got %b want 0", ack0); end
        @(posedge clk); @(negedge clk);
        n_vec++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL single_write_ack0 got %b want 1", ack0); end
        n_vec++; if (ack1 !== 1'b0 || rf_we !== 1'b0) begin n_err++; $display("FAIL single_write_resp got ack1=%b we=%b want 0/0", ack1, rf_we); end
        req0 = 1'b0;
        @(posedge clk); @(negedge clk);
        n_vec++; if (ack0 !== 1'b0 || rf_we !== 1'b0) begin n_err++; $display("FAIL single_write_after got ack0=%b we=%b want 0/0", ack0, rf_we); end
        n_vec++; if (rf_mem[0] !== 32'h0000000f) begin n_err++; $display("FAIL single_write_commit got %h want 0000000f", rf_mem[0]); end
        $display("single_write: c0 wr addr 0 data 0000000f");
    endtask

    task automatic test_readback();
        logic [31:0] vals [8];
        int lat;
        vals = '{32'h0000000f, 32'h000000ff, 32'h0000ff00, 32'h00ff0000,
                 32'hff000000, 32'h0000ffff, 32'h00ffff00, 32'hffff0000};
        for (int a = 1; a < 8; a++) begin
            xact(0, 1'b1, 3'(a), vals[a], lat);
            n_vec++; if (lat != 2) begin n_err++; $display("FAIL rb_write_lat addr %0d got %0d want 2", a, lat); end
            $display("readback: c0 wr addr %0d data %h", a, vals[a]);
        end
        for (int a = 1; a < 8; a++) begin
            xact(1, 1'b0, 3'(a), 32'h0, lat);
            n_vec++; if (lat != 2 || rdata1 !== vals[a]) begin n_err++; $display("FAIL rb_read addr %0d got lat=%0d rdata1=%h want 2/%h", a, lat, rdata1, vals[a]); end
            n_vec++; if (rdata0 !== 32'h0) begin n_err++; $display("FAIL rb_rdata0_touched got %h want 0", rdata0); end
            $display("readback: c1 rd addr %0d data %h", a, rdata1);
        end
    endtask

    task automatic test_simultaneous();
        int t0 = -1, t1 = -1;
        apply_reset();
        req0 = 1'b1; op0 = 1'b1; addr0 = 3'd5; wdata0 = 32'h12345678;
        req1 = 1'b1; op1 = 1'b0; addr1 = 3'd5;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (ack0 === 1'b1 && t0 < 0) begin t0 = cyc; req0 = 1'b0; end
            if (ack1 === 1'b1 && t1 < 0) begin t1 = cyc; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_vec++; if (t0 != 2) begin n_err++; $display("FAIL simul_ack0_time got %0d want 2", t0); end
        n_vec++; if (t1 != 5) begin n_err++; $display("FAIL simul_ack1_time got %0d want 5", t1); end
        n_vec++; if (rdata1 !== 32'h12345678) begin n_err++; $display("FAIL simul_rdata1 got %h want 12345678", rdata1); end
        $display("simultaneous: ack0 at %0d ack1 at %0d rdata1 %h", t0, t1, rdata1);
    endtask

    task automatic test_back_to_back();
        int order [6];
        int nack = 0, we_cnt = 0;
        logic prev_we = 1'b0;
        for (int k = 0; k < 6; k++) order[k] = -1;
        apply_reset();
        req0 = 1'b1; op0 = 1'b1; addr0 = 3'd6; wdata0 = 32'ha5a5a5a5;
        req1 = 1'b1; op1 = 1'b0; addr1 = 3'd6;
        for (int cyc = 0; cyc < 30 && nack < 6; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (prev_we) begin
                n_vec++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL b2b_we_then_ack got ack0=%b want 1", ack0); end
            end
            n_vec++; if (ack0 === 1'b1 && ack1 === 1'b1) begin n_err++; $display("FAIL b2b_dual_ack got 1/1 want one-hot"); end
            if (ack0 === 1'b1) begin order[nack] = 0; nack++; end
            else if (ack1 === 1'b1) begin order[nack] = 1; nack++; end
            if (rf_we === 1'b1) we_cnt++;
            prev_we = rf_we;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_vec++; if (order[k] != k % 2) begin n_err++; $display("FAIL b2b_order slot %0d got %0d want %0d", k, order[k], k % 2); end
            $display("back_to_back: grant %0d to client %0d", k, order[k]);
        end
        n_vec++; if (we_cnt != 3) begin n_err++; $display("FAIL b2b_we_cycles got %0d want 3", we_cnt); end
        n_vec++; if (rdata1 !== 32'ha5a5a5a5) begin n_err++; $display("FAIL b2b_rdata1 got %h want a5a5a5a5", rdata1); end
    endtask

    task automatic test_dropped();
        int acks = 0;
        logic we_seen = 1'b0;
        req1 = 1'b1; op1 = 1'b0; addr1 = 3'd7;
        @(posedge clk); @(negedge clk);
        req1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ack1 === 1'b1) acks++;
            if (rf_we === 1'b1) we_seen = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        n_vec++; if (acks != 1) begin n_err++; $display("FAIL dropped_ack_count got %0d want 1", acks); end
        n_vec++; if (rdata1 !== 32'hffff0000) begin n_err++; $display("FAIL dropped_rdata1 got %h want ffff0000", rdata1); end
        n_vec++; if (we_seen !== 1'b0) begin n_err++; $display("FAIL dropped_we got %b want 0", we_seen); end
        $display("dropped: c1 rd addr 7 acks %0d rdata1 %h", acks, rdata1);
    endtask

    task automatic test_async_reset();
        int lat, t0 = -1, t1 = -1;
        req0 = 1'b1; op0 = 1'b1; addr0 = 3'd2; wdata0 = 32'hdeadbeef;
        @(posedge clk);
        #2;
        n_vec++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL areset_we_before got %b want 1", rf_we); end
        reset = 1'b1;
        #1;
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL areset_we_drop got %b want 0", rf_we); end
        req0 = 1'b0;
        @(posedge clk); @(negedge clk);
        n_vec++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL areset_ack0 got %b want 0", ack0); end
        reset = 1'b0;
        n_vec++; if (rf_mem[2] !== 32'h0000ff00) begin n_err++; $display("FAIL areset_commit got %h want 0000ff00", rf_mem[2]); end
        xact(1, 1'b0, 3'd2, 32'h0, lat);
        n_vec++; if (lat != 2 || rdata1 !== 32'h0000ff00) begin n_err++; $display("FAIL areset_readback got lat=%0d %h want 2/0000ff00", lat, rdata1); end
        // priority pointer back at 1 after reset: client 0 wins the tie
        apply_reset();
        req0 = 1'b1; op0 = 1'b0; addr0 = 3'd1;
        req1 = 1'b1; op1 = 1'b0; addr1 = 3'd4;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (ack0 === 1'b1 && t0 < 0) begin t0 = cyc; req0 = 1'b0; end
            if (ack1 === 1'b1 && t1 < 0) begin t1 = cyc; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_vec++; if (t0 != 2 || t1 != 5) begin n_err++; $display("FAIL areset_tie got ack0@%0d ack1@%0d want 2/5", t0, t1); end
        n_vec++; if (rdata0 !== 32'h000000ff || rdata1 !== 32'hff000000) begin n_err++; $display("FAIL areset_tie_data got %h/%h want 000000ff/ff000000", rdata0, rdata1); end
        $display("async_reset: write aborted, addr 2 reads %h, tie ack0@%0d ack1@%0d", rdata1, t0, t1);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_readback();
        test_simultaneous();
        test_back_to_back();
        test_dropped();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
